// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single pmem port between instruction fetch (IFU) and load/store
//   (LSU). One access is outstanding at a time. The block aligns store data
//   onto byte lanes, builds the write mask, sign/zero-extends load data, rejects
//   misaligned or illegal accesses without touching memory, and bounds every
//   memory response with a timeout.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge where
//   both valid and ready are high. The producer holds valid and its payload
//   stable until that edge; ready carries no promise on cycles without valid.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ifu_valid/ifu_ready/ifu_addr   IFU request channel (always a 4-byte read)
//   ifu_rvalid/ifu_rready          IFU response channel
//   ifu_rdata/ifu_err              fetched word, error (qualified by rvalid)
//   lsu_valid/lsu_ready            LSU request channel
//   lsu_we/lsu_ctr/lsu_addr        store flag, size/extension code, byte address
//   lsu_wdata                      LSB-aligned store data
//   lsu_rvalid/lsu_rready          LSU response channel
//   lsu_rdata/lsu_err              extended load data (0 for stores), error
//   mem_valid/mem_ready            memory request channel
//   mem_wen/mem_addr/mem_wdata     write flag, word address, lane-shifted data
//   mem_wmask                      byte enables (0 for reads)
//   mem_rvalid/mem_rdata           memory response (read data or write ack)
//   dbg_state                      current FSM state (IDLE=0 REQ=1 WAIT=2 RESP=3)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_ctr,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        last_lsu;   // 1: LSU holds the most recent grant
  logic        owner_lsu;  // requester of the access in flight
  logic        we_q;
  logic [2:0]  ctr_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  // Arbitration and the request seen by the winner
  logic        pick_ifu, pick_lsu, grant;
  logic        rq_we, rq_err;
  logic [2:0]  rq_ctr;
  logic [31:0] rq_addr, rq_wdata;

  function automatic logic access_err(input logic [2:0] ctr, input logic [1:0] off);
    case (ctr)
      3'b000, 3'b100: access_err = 1'b0;
      3'b001, 3'b101: access_err = off[0];
      3'b010:         access_err = (off != 2'b00);
      default:        access_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] ctr, input logic [1:0] off);
    case (ctr[1:0])
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << off;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] ctr, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (ctr)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extract = {24'h0, sh[7:0]};
      3'b101:  extract = {16'h0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // Round-robin: on contention the requester that did not win last time wins.
  always_comb begin
    pick_ifu = 1'b0;
    pick_lsu = 1'b0;
    if (!rst && state == S_IDLE) begin
      if (ifu_valid && lsu_valid) begin
        pick_lsu = !last_lsu;
        pick_ifu = last_lsu;
      end else begin
        pick_lsu = lsu_valid;
        pick_ifu = ifu_valid;
      end
    end
  end

  always_comb begin
    grant    = pick_ifu | pick_lsu;
    rq_we    = pick_lsu & lsu_we;
    rq_ctr   = pick_lsu ? lsu_ctr   : 3'b010;
    rq_addr  = pick_lsu ? lsu_addr  : ifu_addr;
    rq_wdata = pick_lsu ? lsu_wdata : 32'h0;
    rq_err   = access_err(rq_ctr, rq_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last_lsu  <= 1'b0;
      owner_lsu <= 1'b0;
      we_q      <= 1'b0;
      ctr_q     <= 3'b000;
      off_q     <= 2'b00;
      cnt       <= 8'd0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner_lsu <= pick_lsu;
            last_lsu  <= pick_lsu;
            we_q      <= rq_we;
            ctr_q     <= rq_ctr;
            off_q     <= rq_addr[1:0];
            mem_wen   <= rq_we;
            mem_addr  <= {rq_addr[31:2], 2'b00};
            mem_wdata <= rq_wdata << {rq_addr[1:0], 3'b000};
            mem_wmask <= rq_we ? store_mask(rq_ctr, rq_addr[1:0]) : 4'h0;
            rdata_q   <= 32'h0;
            err_q     <= rq_err;
            // A rejected access answers straight away and never reaches memory.
            state     <= rq_err ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            cnt   <= 8'd0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // mem_rvalid is only looked at here; late beats in RESP/IDLE are dropped.
          if (mem_rvalid) begin
            rdata_q <= we_q ? 32'h0 : extract(ctr_q, off_q, mem_rdata);
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (cnt == TO_LAST) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (owner_lsu ? lsu_rready : ifu_rready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ifu_ready  = pick_ifu;
  assign lsu_ready  = pick_lsu;
  assign mem_valid  = (state == S_REQ);
  assign ifu_rvalid = (state == S_RESP) && !owner_lsu;
  assign lsu_rvalid = (state == S_RESP) && owner_lsu;
  assign ifu_rdata  = rdata_q;
  assign lsu_rdata  = rdata_q;
  assign ifu_err    = err_q;
  assign lsu_err    = err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. The memory wrapper is modelled as a byte array
// answering after a random delay; expected responses come from a separate
// byte-level reference memory updated by size/offset arithmetic.
module tb_mem_arbiter;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ifu_valid, ifu_ready, ifu_rvalid, ifu_rready, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_valid, lsu_ready, lsu_we, lsu_rvalid, lsu_rready, lsu_err;
  logic [2:0]  lsu_ctr;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic [1:0]  dbg_state;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we), .lsu_ctr(lsu_ctr),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];  // {err, rdata} per accepted request

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_b[64];
  logic [7:0] mem_b[64];

  function automatic int size_of(input logic [2:0] ctr);
    case (ctr)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Returns {err, rdata}; stores update the reference memory.
  function automatic logic [32:0] model_access(input logic is_lsu, input logic we,
      input logic [2:0] ctr, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    int base;
    logic [31:0] v;
    n = is_lsu ? size_of(ctr) : 4;
    base = int'(addr[5:0]);
    v = 32'h0;
    if (n == 0) return {1'b1, 32'h0};
    if ((int'(addr[1:0]) % n) != 0) return {1'b1, 32'h0};
    if (is_lsu && we) begin
      for (int i = 0; i < n; i++) ref_b[base + i] = wdata[8*i +: 8];
      return {1'b0, 32'h0};
    end
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[base + i];
    if (n < 4 && ctr[2] == 1'b0 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return {1'b0, v};
  endfunction

  function automatic logic [3:0] model_mask(input logic we, input logic [2:0] ctr,
                                            input logic [31:0] addr);
    logic [3:0] m;
    m = 4'h0;
    if (we) for (int i = 0; i < size_of(ctr); i++) m[int'(addr[1:0]) + i] = 1'b1;
    return m;
  endfunction

  // ---------------- memory wrapper model ----------------
  int          mem_hs_cnt = 0;
  int          mem_valid_cyc = 0;
  int          force_delay = 0;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_mask;
  logic        obs_wen;

  initial begin
    int cnt;
    logic [31:0] rd;
    cnt = 0;
    rd = 32'h0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0;
      end else begin
        if (mem_valid) mem_valid_cyc++;
        if (mem_valid && mem_ready) begin
          mem_hs_cnt++;
          obs_addr = mem_addr;
          obs_wdata = mem_wdata;
          obs_mask = mem_wmask;
          obs_wen = mem_wen;
          for (int j = 0; j < 4; j++)
            if (mem_wen && mem_wmask[j]) mem_b[{mem_addr[5:2], 2'(j)}] = mem_wdata[8*j +: 8];
          rd = {mem_b[{mem_addr[5:2], 2'd3}], mem_b[{mem_addr[5:2], 2'd2}],
                mem_b[{mem_addr[5:2], 2'd1}], mem_b[{mem_addr[5:2], 2'd0}]};
          cnt = (force_delay != 0) ? force_delay : int'($urandom_range(1, 3));
        end
      end
      @(posedge clk);
      #1;
      mem_ready = ($urandom_range(0, 3) != 0);
      if (cnt == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
      end
      if (cnt > 0) cnt--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One full transaction on one requester; starts and ends just after posedge.
  task automatic do_req(input logic is_lsu, input logic we, input logic [2:0] ctr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic timeout_exp, output logic [32:0] resp);
    logic [32:0] exp, first, got;
    logic accepted, seen, done, other_seen;
    int hs0, vc0;
    exp = model_access(is_lsu, we, ctr, addr, wdata);
    if (timeout_exp) exp = {1'b1, 32'h0};
    exp_q.push_back(exp);
    hs0 = mem_hs_cnt;
    vc0 = mem_valid_cyc;
    if (is_lsu) begin
      lsu_valid = 1'b1; lsu_we = we; lsu_ctr = ctr; lsu_addr = addr; lsu_wdata = wdata;
    end else begin
      ifu_valid = 1'b1; ifu_addr = addr;
    end
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) begin
      @(negedge clk);
      accepted = is_lsu ? lsu_ready : ifu_ready;
      @(posedge clk);
      #1;
    end
    lsu_valid = 1'b0; ifu_valid = 1'b0;
    lsu_addr = $urandom; lsu_wdata = $urandom; ifu_addr = $urandom;
    check("accept", 32'(accepted), 32'd1);
    seen = 1'b0; done = 1'b0; other_seen = 1'b0;
    first = 33'h0; got = 33'h0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (is_lsu) lsu_rready = 1'($urandom_range(0, 1));
      else ifu_rready = 1'($urandom_range(0, 1));
      @(negedge clk);
      other_seen |= is_lsu ? ifu_rvalid : lsu_rvalid;
      got = is_lsu ? {lsu_err, lsu_rdata} : {ifu_err, ifu_rdata};
      if (is_lsu ? lsu_rvalid : ifu_rvalid) begin
        if (!seen) first = got;
        seen = 1'b1;
        if (is_lsu ? lsu_rready : ifu_rready) done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    lsu_rready = 1'b0; ifu_rready = 1'b0;
    exp = exp_q.pop_front();
    resp = got;
    check("resp_seen", 32'(done), 32'd1);
    check("other_rvalid", 32'(other_seen), 32'd0);
    check("rdata", got[31:0], exp[31:0]);
    check("err", 32'(got[32]), 32'(exp[32]));
    check("resp_hold", got[31:0], first[31:0]);
    if (exp[32] && !timeout_exp) begin
      check("no_mem_access", 32'(mem_valid_cyc - vc0), 32'd0);
    end else begin
      check("mem_hs", 32'(mem_hs_cnt - hs0), 32'd1);
      check("mem_addr", obs_addr, {addr[31:2], 2'b00});
      check("mem_wen", 32'(obs_wen), 32'(is_lsu && we));
      check("mem_wmask", 32'(obs_mask), 32'(model_mask(is_lsu && we, ctr, addr)));
      if (is_lsu && we) check("mem_wdata", obs_wdata, wdata << (8 * int'(addr[1:0])));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [32:0] resp;
    int grants[$];
    int nresp, both, stray, off;
    logic in_wait, is_lsu, we;
    logic [2:0] ctr;
    logic [32:0] exp_i, exp_l;

    rst = 1'b1;
    ifu_valid = 1'b0; ifu_addr = 32'h0; ifu_rready = 1'b0;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_ctr = 3'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
    lsu_rready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ref_b[i] = 8'($urandom);
      mem_b[i] = ref_b[i];
    end
    ref_b[0] = 8'h00; ref_b[1] = 8'h00; ref_b[2] = 8'h00; ref_b[3] = 8'h8A;
    for (int i = 0; i < 4; i++) mem_b[i] = ref_b[i];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_valids", 32'({ifu_ready, lsu_ready, ifu_rvalid, lsu_rvalid, mem_valid}), 32'd0);
    check("rst_rdata", ifu_rdata | lsu_rdata, 32'h0);
    check("rst_err", 32'({ifu_err, lsu_err}), 32'd0);
    @(posedge clk);
    #1;

    // Directed load/store vectors
    do_req(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 1'b0, resp);
    check("lbu_value", resp[31:0], 32'h0000_008A);
    check("lbu_err", 32'(resp[32]), 32'd0);
    do_req(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 1'b0, resp);
    check("lb_value", resp[31:0], 32'hFFFF_FF8A);
    do_req(1'b1, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 1'b0, resp);
    check("sh_wmask", 32'(obs_mask), 32'b1100);
    check("sh_wdata", obs_wdata, 32'hABCD_0000);
    check("sh_addr", obs_addr, 32'h8000_0000);
    do_req(1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'h0, 1'b0, resp);
    check("lw_misaligned_err", 32'(resp[32]), 32'd1);

    // Both requesters valid from reset: LSU, IFU, LSU, ...
    do_reset();
    exp_i = model_access(1'b0, 1'b0, 3'b010, 32'h8000_0010, 32'h0);
    exp_l = model_access(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0);
    ifu_addr = 32'h8000_0010; ifu_valid = 1'b1; ifu_rready = 1'b1;
    lsu_we = 1'b0; lsu_ctr = 3'b010; lsu_addr = 32'h8000_0020; lsu_valid = 1'b1; lsu_rready = 1'b1;
    nresp = 0; both = 0;
    for (int k = 0; k < 200 && nresp < 6; k++) begin
      @(negedge clk);
      if (ifu_ready && lsu_ready) both++;
      if (lsu_ready) grants.push_back(1);
      else if (ifu_ready) grants.push_back(0);
      if (lsu_rvalid) begin
        nresp++;
        check("rr_lsu_rdata", lsu_rdata, exp_l[31:0]);
      end
      if (ifu_rvalid) begin
        nresp++;
        check("rr_ifu_rdata", ifu_rdata, exp_i[31:0]);
      end
      @(posedge clk);
      #1;
      if (grants.size() >= 6) begin
        ifu_valid = 1'b0; lsu_valid = 1'b0;
      end
    end
    ifu_valid = 1'b0; lsu_valid = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
    check("rr_resp_count", 32'(nresp), 32'd6);
    check("rr_grant_count", 32'(grants.size()), 32'd6);
    check("rr_dual_ready", 32'(both), 32'd0);
    foreach (grants[i]) check("rr_grant_order", 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

    // Timeout: no mem_rvalid for TO cycles, then a late beat that must be ignored
    force_delay = TO + 2;
    do_req(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 1'b1, resp);
    force_delay = 0;
    check("timeout_err", 32'(resp[32]), 32'd1);
    check("timeout_rdata", resp[31:0], 32'h0);
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ifu_rvalid || lsu_rvalid || mem_valid || dbg_state != 2'd0) stray++;
      @(posedge clk);
      #1;
    end
    check("late_rvalid_ignored", 32'(stray), 32'd0);

    // Reset while waiting on memory
    force_delay = 100;
    lsu_we = 1'b0; lsu_ctr = 3'b010; lsu_addr = 32'h8000_0008; lsu_valid = 1'b1;
    in_wait = 1'b0;
    for (int k = 0; k < 40 && !in_wait; k++) begin
      @(negedge clk);
      if (lsu_ready) lsu_valid_drop_pending: begin end
      in_wait = (dbg_state == 2'd2);
      @(posedge clk);
      #1;
      if (!lsu_ready) lsu_valid = lsu_valid && (dbg_state == 2'd0);
    end
    lsu_valid = 1'b0;
    check("rst_reach_wait", 32'(in_wait), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    force_delay = 0;
    @(negedge clk);
    check("midrst_state", 32'(dbg_state), 32'd0);
    check("midrst_valids", 32'({ifu_rvalid, lsu_rvalid, mem_valid}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_req(1'b0, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 1'b0, resp);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      is_lsu = 1'($urandom_range(0, 1));
      we = is_lsu ? 1'($urandom_range(0, 1)) : 1'b0;
      ctr = 3'($urandom_range(0, 7));
      off = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (is_lsu && ctr[1:0] == 2'b01) off = off & ~1;
        if (!is_lsu || ctr == 3'b010) off = off & ~3;
      end
      do_req(is_lsu, we, ctr, 32'h8000_0000 + 32'(off), $urandom, 1'b0, resp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no summary by time 200000, expected completion");
    $fatal(1);
  end

endmodule
